// File: rtl/music_pkg.sv
// Shared definitions for the score sequencer: note codes, entry layout, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package music_pkg;

  // Note codes {level[1:0], note[2:0]}; level 0 means silence/rest.
  localparam logic [4:0] REST  = 5'b00000;
  localparam logic [4:0] L1_DO = 5'b01001, L1_RE = 5'b01010, L1_MI = 5'b01011, L1_FA = 5'b01100,
                         L1_SO = 5'b01101, L1_LA = 5'b01110, L1_SI = 5'b01111;
  localparam logic [4:0] L2_DO = 5'b10001, L2_RE = 5'b10010, L2_MI = 5'b10011, L2_FA = 5'b10100,
                         L2_SO = 5'b10101, L2_LA = 5'b10110, L2_SI = 5'b10111;
  localparam logic [4:0] L3_DO = 5'b11001, L3_RE = 5'b11010, L3_MI = 5'b11011, L3_FA = 5'b11100,
                         L3_SO = 5'b11101, L3_LA = 5'b11110, L3_SI = 5'b11111;

  // Score entry: [7:3] note code, [2:0] duration minus one; all-zero word ends the score.
  localparam logic [7:0] END_MARK = 8'h00;
  localparam int CODE_HI = 7;
  localparam int CODE_LO = 3;
  localparam int DUR_HI  = 2;
  localparam int DUR_LO  = 0;

  // Sequencer states.
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_FETCH = 3'd1;
  localparam state_t S_WAIT  = 3'd2;
  localparam state_t S_PLAY  = 3'd3;
  localparam state_t S_GAP   = 3'd4;

  // A code with level 0 is a rest: no articulation gap follows it.
  function automatic logic is_rest(input logic [4:0] code);
    return (code[4:3] == 2'b00);
  endfunction

endpackage

// File: rtl/music_seq_score_rom.sv
// Score ROM, 2**ADDR_W x 8, contents supplied as a packed image (entry 0 in the LSBs).
// Latency: 1 cycle, registered read data.
// Backpressure: none; reads every cycle.
module score_rom
  import music_pkg::*;
#(
  parameter int                         ADDR_W = 6,
  parameter logic [(2**ADDR_W)*8-1:0]   SCORE  = '0
) (
  input  logic              clk_1mhz,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [7:0]        o_data
);

  logic [7:0] r_data;

  // Synchronous read of the addressed entry.
  always_ff @(posedge clk_1mhz) begin
    r_data <= SCORE[{i_addr, 3'b000} +: 8];
  end

  assign o_data = r_data;

endmodule

// File: rtl/music_seq.sv
// Score sequencer: walks the score ROM and holds each note code for its duration, with gaps.
// Latency: 2 silent fetch cycles per entry; stop takes effect on the next cycle.
// Backpressure: pause level freezes PLAY/GAP counters and mutes note_data.
module music_seq
  import music_pkg::*;
#(
  parameter int                         BEAT_US = 250000,
  parameter int                         GAP_US  = 10000,
  parameter int                         ADDR_W  = 6,
  parameter logic [(2**ADDR_W)*8-1:0]   SCORE   = '0
) (
  input  logic              clk_1mhz,
  input  logic              rst_n,
  input  logic              play,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop,
  output logic [4:0]        note_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] cur_addr
);

  localparam int TW = (BEAT_US > 1) ? $clog2(BEAT_US) : 1;
  localparam logic [TW-1:0] BEAT_LAST = TW'(BEAT_US - 1);
  // Last tick of the final unit for a sounding note; the rest of that unit is the gap.
  localparam logic [TW-1:0] NOTE_LAST = TW'(BEAT_US - 1 - GAP_US);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_US - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [4:0]        r_code;
  logic [2:0]        r_units;
  logic [TW-1:0]     r_tick;

  logic [7:0]        w_rom_word;
  logic              w_end;
  logic              w_rest;
  logic [TW-1:0]     w_play_last;

  score_rom #(
    .ADDR_W (ADDR_W),
    .SCORE  (SCORE)
  ) u_rom (
    .clk_1mhz (clk_1mhz),
    .i_addr   (r_addr),
    .o_data   (w_rom_word)
  );

  assign w_end       = (w_rom_word == END_MARK);
  assign w_rest      = is_rest(r_code);
  assign w_play_last = w_rest ? BEAT_LAST : NOTE_LAST;

  // Playback FSM with beat tick counter and remaining-unit counter.
  always_ff @(posedge clk_1mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_code  <= REST;
      r_units <= 3'd0;
      r_tick  <= '0;
    end else if (stop) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (play) begin
            r_addr  <= '0;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: r_state <= S_WAIT;
        S_WAIT: begin
          if (w_end) begin
            if (loop) begin
              r_addr  <= '0;
              r_state <= S_FETCH;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_code  <= w_rom_word[CODE_HI:CODE_LO];
            r_units <= w_rom_word[DUR_HI:DUR_LO];
            r_tick  <= '0;
            r_state <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (!pause) begin
            if (r_units == 3'd0 && r_tick == w_play_last) begin
              r_tick <= '0;
              if (w_rest) begin
                r_addr  <= r_addr + 1'b1;
                r_state <= S_FETCH;
              end else begin
                r_state <= S_GAP;
              end
            end else if (r_tick == BEAT_LAST) begin
              r_tick  <= '0;
              r_units <= r_units - 3'd1;
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
        end
        S_GAP: begin
          if (!pause) begin
            if (r_tick == GAP_LAST) begin
              r_tick  <= '0;
              r_addr  <= r_addr + 1'b1;
              r_state <= S_FETCH;
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign note_data = (r_state == S_PLAY && !pause) ? r_code : REST;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_WAIT) && w_end && !loop && !stop;
  assign cur_addr  = r_addr;

endmodule
